window_minmax: RTL
==================

# window_minmax

Streaming signed min/max reducer; sits directly downstream of `comparator_lt`/`comparator_eq` and uses them as its datapath. It accepts a stream of signed N-bit samples over a valid/ready handshake, reduces each group of WINDOW consecutive samples to its minimum and maximum, and presents the pair on a second valid/ready handshake. It is the first sequential consumer of the comparators and serves as a peak detector for the lab datapath.

## Interface
- `N`, 32, sample width in bits; samples are two's-complement signed.
- `WINDOW`, 8, samples per reduction; legal range 2..256.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on the `clk` rising edge.
- `in_valid`  in  1  upstream sample present.
- `in_ready`  out  1  block can accept a sample this cycle.
- `in_data`  in  N  signed sample.
- `out_valid`  out  1  result held on `out_min`/`out_max`.
- `out_ready`  in  1  downstream accepts the result.
- `out_min`  out  N  signed minimum of the window.
- `out_max`  out  N  signed maximum of the window.
- `out_min_idx`, `out_max_idx`  out  $clog2(WINDOW)  position within the window (0 = first sample); present only with `WINDOW_MINMAX_IDX_EN`.

## Operation
- Transfer on the input side when `in_valid && in_ready`; transfer on the output side when `out_valid && out_ready`.
- FSM states:
  - **S_FIRST**: `in_ready`=1. On transfer, load `in_data` into both min and max, set count=1, and go to S_ACCUM.
  - **S_ACCUM**: `in_ready`=1. On transfer, update min if `in_data < min`, and update max if `max < in_data`.
    - Both tests are strict signed compares through `comparator_lt`.
    - Ties keep the earlier sample, which matters for the index outputs.
    - If count == WINDOW-1, go to S_OUT; otherwise count++.
  - **S_OUT**: `in_ready`=0, `out_valid`=1. Outputs hold stable until transfer. On transfer, go to S_FIRST.
- A single sample may update both min and max only in S_FIRST. In S_ACCUM the two updates are independent and both are evaluated every accepted sample.
- `in_valid` low in any state: the FSM holds all state.
- Reset mid-window: the partial window is discarded, with no output.

## Timing
- Reset values: state=S_FIRST, count=0, `out_valid`=0, `out_min`=0, `out_max`=0, index outputs 0.
- `in_ready` is forced 0 while `rst` is low. It is 1 in the first cycle after reset deasserts.
- Latency: `out_valid` rises the cycle after the WINDOW-th sample is accepted.
- Minimum period is WINDOW+1 cycles per window. There is no input/output overlap and no bypass: `in_ready` stays 0 in the cycle of the output transfer.
- `out_min`/`out_max` are registered outputs, with no combinational path from `in_data`.
- `out_ready` held high before `out_valid` is harmless. `out_valid` never drops without a transfer, except on reset.

## Configuration
- `WINDOW_MINMAX_IDX_EN` defined:
  - Index registers are built and track the count value at which min/max was last updated; an update in S_FIRST sets the index to 0.
  - The `out_min_idx`/`out_max_idx` ports exist.
- Undefined: the index registers and ports are absent, and all other behaviour is identical.

## Structure
- `window_minmax_pkg`:
  - state enum `minmax_state_t` {S_FIRST, S_ACCUM, S_OUT};
  - function `cnt_w(WINDOW)` returning max(1,$clog2(WINDOW)).
- Sub-module `minmax_update`: combinational.
  - Takes cur_min, cur_max and sample; returns next_min, next_max, min_upd, max_upd.
  - Built from two `comparator_lt` instances.
- The top level holds the FSM, count and registers only.

## Test plan
- Reset then WINDOW=8 samples 5,−3,12,0,7,−3,12,1 with `out_ready`=1 -> `out_min`=−3, `out_max`=12, `out_valid` one cycle after 8th accept; with IDX_EN, min_idx=1, max_idx=2 (earliest tie).
- Extremes: samples include 32'h8000_0000 and 32'h7FFF_FFFF -> min=−2147483648, max=2147483647 (signed, not unsigned ordering).
- Backpressure: `out_ready`=0 for 5 cycles after `out_valid` -> outputs stable, `in_ready`=0, no sample accepted; transfer, then next window reduces independently.
- Bubbles: `in_valid` toggled 1/0 randomly across a window of all-equal values 42 -> min=max=42, idx 0, count unaffected by idle cycles.
- Reset asserted after 4 of 8 samples -> `out_valid` stays 0; next 8 samples produce a result from those 8 only.
- Random: 100 windows of `$random` samples against a behavioural signed min/max model; zero mismatches.

Source files
------------

// File: rtl/window_minmax_pkg.sv
// Shared types and sizing helpers for the windowed signed min/max reducer.
package window_minmax_pkg;

  typedef enum logic [1:0] {
    S_FIRST = 2'd0,
    S_ACCUM = 2'd1,
    S_OUT   = 2'd2
  } minmax_state_t;

  // Counter width; never zero even for degenerate window sizes.
  function automatic int unsigned cnt_w(input int unsigned window);
    int unsigned w;
    w = $clog2(window);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/comparator_lt.sv
// Strict two's-complement less-than: lt = (a < b) with a and b signed.
module comparator_lt #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt
);

  assign lt = $signed(a) < $signed(b);

endmodule

// File: rtl/window_minmax_update.sv
// Combinational min/max update step built from two strict signed comparators.
module minmax_update #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] cur_min,
  input  logic [N-1:0] cur_max,
  input  logic [N-1:0] sample,
  output logic [N-1:0] next_min,
  output logic [N-1:0] next_max,
  output logic         min_upd,
  output logic         max_upd
);

  // Strict compares: a tie never displaces the earlier sample.
  comparator_lt #(.N(N)) u_min_lt (
    .a  (sample),
    .b  (cur_min),
    .lt (min_upd)
  );

  comparator_lt #(.N(N)) u_max_lt (
    .a  (cur_max),
    .b  (sample),
    .lt (max_upd)
  );

  assign next_min = min_upd ? sample : cur_min;
  assign next_max = max_upd ? sample : cur_max;

endmodule

// File: rtl/window_minmax.sv
// Streaming signed min/max over groups of WINDOW samples, valid/ready on both sides.
// Define WINDOW_MINMAX_IDX_EN to add out_min_idx/out_max_idx position outputs.
module window_minmax
  import window_minmax_pkg::*;
#(
  parameter int unsigned N      = 32,
  parameter int unsigned WINDOW = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_min,
  output logic [N-1:0]               out_max
`ifdef WINDOW_MINMAX_IDX_EN
  ,
  output logic [$clog2(WINDOW)-1:0]  out_min_idx,
  output logic [$clog2(WINDOW)-1:0]  out_max_idx
`endif
);

  localparam int unsigned CW = cnt_w(WINDOW);
  localparam logic [CW-1:0] LastCnt = CW'(WINDOW - 1);

  minmax_state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  min_q, min_d, max_q, max_d;
  logic [N-1:0]  next_min, next_max;
  logic          min_upd, max_upd;
  logic          in_fire;

  minmax_update #(.N(N)) u_update (
    .cur_min  (min_q),
    .cur_max  (max_q),
    .sample   (in_data),
    .next_min (next_min),
    .next_max (next_max),
    .min_upd  (min_upd),
    .max_upd  (max_upd)
  );

`ifdef WINDOW_MINMAX_IDX_EN
  logic [CW-1:0] min_idx_q, min_idx_d, max_idx_q, max_idx_d;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    min_d     = min_q;
    max_d     = max_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef WINDOW_MINMAX_IDX_EN
    min_idx_d = min_idx_q;
    max_idx_d = max_idx_q;
`endif
    unique case (state_q)
      S_FIRST: begin
        in_ready = rst;
        if (in_fire) begin
          min_d   = in_data;
          max_d   = in_data;
          count_d = CW'(1);
          state_d = S_ACCUM;
`ifdef WINDOW_MINMAX_IDX_EN
          min_idx_d = '0;
          max_idx_d = '0;
`endif
        end
      end
      S_ACCUM: begin
        in_ready = rst;
        if (in_fire) begin
          min_d = next_min;
          max_d = next_max;
`ifdef WINDOW_MINMAX_IDX_EN
          if (min_upd) min_idx_d = count_q;
          if (max_upd) max_idx_d = count_q;
`endif
          if (count_q == LastCnt) state_d = S_OUT;
          else                    count_d = count_q + CW'(1);
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_FIRST;
      end
      default: state_d = S_FIRST;
    endcase
  end

  assign in_fire = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FIRST;
      count_q <= '0;
      min_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      min_q   <= min_d;
      max_q   <= max_d;
    end
  end

`ifdef WINDOW_MINMAX_IDX_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      min_idx_q <= '0;
      max_idx_q <= '0;
    end else begin
      min_idx_q <= min_idx_d;
      max_idx_q <= max_idx_d;
    end
  end

  assign out_min_idx = min_idx_q;
  assign out_max_idx = max_idx_q;
`endif

  assign out_min = min_q;
  assign out_max = max_q;

endmodule
